// File: rtl/decoder_scan_sequencer.sv
// Row-select sequencer feeding a 4-to-16 decoder: steps sel through 0..last with
// a fixed dwell per row and optional blanking gaps, single-pass or continuous.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs quiet
// S_SCAN  | current row held active for DWELL cycles
// S_BLANK | decoder gated off while sel settles on the next row
// S_DONE  | one-cycle termination pulse, sel still holds the final row
module decoder_scan_sequencer #(
    parameter int DWELL = 8,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [3:0] last,
    output logic [3:0] sel,
    output logic       active,
    output logic       row_tick,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BLANK, S_DONE} state_t;

    // Down-counters load N-1 and terminate on zero.
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK - 1);
    localparam bit         HAS_BLANK  = (BLANK > 0);

    state_t     state, state_nx;
    logic [3:0] sel_nx, last_q, last_nx, next_row;
    logic       cont_q, cont_nx, stop_q, stop_nx, stop_seen;
    logic [7:0] cnt, cnt_nx;
    logic       active_nx, row_tick_nx, busy_nx, done_nx;

    assign next_row  = (sel == last_q) ? 4'd0 : sel + 4'd1;
    assign stop_seen = stop_q | stop;

    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        last_nx     = last_q;
        cont_nx     = cont_q;
        stop_nx     = stop_q;
        cnt_nx      = cnt;
        active_nx   = 1'b0;
        row_tick_nx = 1'b0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                sel_nx  = 4'd0;
                stop_nx = 1'b0;
                if (start) begin
                    last_nx     = last;
                    cont_nx     = cont;
                    stop_nx     = stop;
                    state_nx    = S_SCAN;
                    cnt_nx      = DWELL_LOAD;
                    active_nx   = 1'b1;
                    row_tick_nx = 1'b1;
                    busy_nx     = 1'b1;
                end
            end
            S_SCAN: begin
                busy_nx = 1'b1;
                stop_nx = stop_seen;
                if (cnt != 8'd0) begin
                    cnt_nx    = cnt - 8'd1;
                    active_nx = 1'b1;
                end else if (stop_seen || (sel == last_q && !cont_q)) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else if (HAS_BLANK) begin
                    state_nx = S_BLANK;
                    sel_nx   = next_row;
                    cnt_nx   = BLANK_LOAD;
                end else begin
                    sel_nx      = next_row;
                    cnt_nx      = DWELL_LOAD;
                    active_nx   = 1'b1;
                    row_tick_nx = 1'b1;
                end
            end
            S_BLANK: begin
                busy_nx = 1'b1;
                stop_nx = stop_seen;
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    state_nx    = S_SCAN;
                    cnt_nx      = DWELL_LOAD;
                    active_nx   = 1'b1;
                    row_tick_nx = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                sel_nx   = 4'd0;
                stop_nx  = 1'b0;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sel      <= 4'd0;
            last_q   <= 4'd0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            cnt      <= 8'd0;
            active   <= 1'b0;
            row_tick <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            last_q   <= last_nx;
            cont_q   <= cont_nx;
            stop_q   <= stop_nx;
            cnt      <= cnt_nx;
            active   <= active_nx;
            row_tick <= row_tick_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: one instance with DWELL=4/BLANK=1,
// one with DWELL=2/BLANK=0. Outputs packed as {sel, active, row_tick, busy, done}.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, stop_a, cont_a;
    logic [3:0] last_a, sel_a;
    logic       active_a, row_tick_a, busy_a, done_a;
    logic       start_b, stop_b, cont_b;
    logic [3:0] last_b, sel_b;
    logic       active_b, row_tick_b, busy_b, done_b;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL(4), .BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .cont(cont_a),
        .last(last_a), .sel(sel_a), .active(active_a), .row_tick(row_tick_a),
        .busy(busy_a), .done(done_a)
    );

    decoder_scan_sequencer #(.DWELL(2), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .cont(cont_b),
        .last(last_b), .sel(sel_b), .active(active_b), .row_tick(row_tick_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] obs_a();
        return {sel_a, active_a, row_tick_a, busy_a, done_a};
    endfunction

    function automatic logic [7:0] obs_b();
        return {sel_b, active_b, row_tick_b, busy_b, done_b};
    endfunction

    // Timing model for DWELL=4, BLANK=1: row k starts at cycle 1+5k, blank at phase 4.
    function automatic logic [7:0] exp_pass(input int c, input int lst, input bit cnt_mode);
        int k, ph, row, nrow;
        if (!cnt_mode && c == 5 * lst + 5) return {4'(lst), 4'b0011};
        if (!cnt_mode && c > 5 * lst + 5) return 8'h00;
        k    = (c - 1) / 5;
        ph   = (c - 1) % 5;
        row  = k % (lst + 1);
        nrow = (row == lst) ? 0 : row + 1;
        if (ph < 4) return {4'(row), 1'b1, (ph == 0), 1'b1, 1'b0};
        return {4'(nrow), 4'b0010};
    endfunction

    task automatic run_single(input int lst, input int model_lst, input bit poke, input bit with_stop);
        last_a  = 4'(lst);
        cont_a  = 1'b0;
        stop_a  = with_stop;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        stop_a  = 1'b0;
        for (int c = 1; c <= 5 * model_lst + 6; c++) begin
            chk($sformatf("pass_L%0d_c%0d", lst, c), obs_a(), exp_pass(c, model_lst, 1'b0));
            if (poke && c == 3) last_a = 4'd9;
            if (poke && c == 6) start_a = 1'b1;
            if (poke && c == 7) start_a = 1'b0;
            tick();
        end
    endtask

    logic [7:0] exp_b [1:8];

    initial begin
        rst = 1'b1;
        {start_a, stop_a, cont_a, last_a} = '0;
        {start_b, stop_b, cont_b, last_b} = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_idle_a", obs_a(), 8'h00);
        chk("reset_idle_b", obs_b(), 8'h00);
        tick();

        // Plain single pass, last=3: done in cycle 20, idle in 21
        run_single(3, 3, 1'b0, 1'b0);
        // start pulse mid-row-1 and last change to 9 must both be ignored
        run_single(3, 3, 1'b1, 1'b0);
        // Single-row scans: last=0, and start+stop together with last=7
        run_single(0, 0, 1'b0, 1'b0);
        run_single(7, 0, 1'b0, 1'b1);

        // Continuous full wrap, stop in 2nd cycle of row 5 on the second pass
        last_a  = 4'd15;
        cont_a  = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cont_a  = 1'b0;
        for (int c = 1; c <= 111; c++) begin
            if (c <= 109)
                chk($sformatf("cont_c%0d", c), obs_a(), exp_pass(c, 15, 1'b1));
            else if (c == 110)
                chk("cont_done", obs_a(), {4'd5, 4'b0011});
            else
                chk("cont_idle", obs_a(), 8'h00);
            stop_a = (c == 107);
            tick();
        end
        stop_a = 1'b0;

        // Reset during row 2 of a single pass, held for two edges
        last_a  = 4'd3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        chk("pre_reset_row2", obs_a(), {4'd2, 4'b1010});
        rst = 1'b1;
        tick();
        chk("reset_mid_1", obs_a(), 8'h00);
        tick();
        chk("reset_mid_2", obs_a(), 8'h00);
        rst = 1'b0;
        tick();
        chk("reset_mid_idle", obs_a(), 8'h00);
        run_single(2, 2, 1'b0, 1'b0);

        // No blanking: DWELL=2, last=2 -> rows back-to-back, done in cycle 7
        exp_b[1] = {4'd0, 4'b1110};
        exp_b[2] = {4'd0, 4'b1010};
        exp_b[3] = {4'd1, 4'b1110};
        exp_b[4] = {4'd1, 4'b1010};
        exp_b[5] = {4'd2, 4'b1110};
        exp_b[6] = {4'd2, 4'b1010};
        exp_b[7] = {4'd2, 4'b0011};
        exp_b[8] = 8'h00;
        last_b  = 4'd2;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("noblank_c%0d", c), obs_b(), exp_b[c]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Upstream address generator for the 4-to-16 decoder. It steps a 4-bit row select through 0..`last`, holding each row for a fixed dwell time with blanking gaps between rows, in single-pass or continuous mode. Typical loads are LED/keypad row scanning and time-multiplexed enables. `sel` drives the decoder inputs and `active` gates the decoder outputs.

## Interface
- `DWELL`, default 8: cycles each row is held active. Legal range is 1..255.
- `BLANK`, default 1: blanking cycles between consecutive rows. Legal range is 0..255.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan. Sampled only in IDLE.
- `stop`  in  1  request end of a continuous scan. Sampled while busy, and in the same cycle as an accepted `start`.
- `cont`  in  1  1 = wrap from `last` back to row 0 and keep going; 0 = single pass. Latched at start.
- `last`  in  4  highest row index to scan. Latched at start.
- `sel`  out  4  row select. `sel[0]` drives decoder `in0` … `sel[3]` drives `in3`.
- `active`  out  1  1 = selected row is valid and decoder outputs may be enabled.
- `row_tick`  out  1  one-cycle pulse on the first cycle of each row's dwell.
- `busy`  out  1  high in SCAN, BLANK and DONE.
- `done`  out  1  one-cycle pulse when the scan terminates.

## Operation
- All outputs are registered (Moore); none depend combinationally on inputs.
- On `rst`, the next edge forces IDLE from any state. Outputs are `sel`=0, `active`=0, `row_tick`=0, `busy`=0, `done`=0. Latched `last`/`cont`, the pending-stop flag and the dwell/blank counters all clear.
- States: IDLE, SCAN, BLANK, DONE.
- **IDLE**
  - `start`=1 latches `last`→`last_q` and `cont`→`cont_q`, then goes to SCAN with `sel`=0, `active`=1, `row_tick`=1.
  - `stop` alone is ignored.
- **SCAN**
  - `active`=1 for exactly `DWELL` cycles.
  - At the end of the dwell, the next state is chosen in this priority order:
    - If stop is pending, or (`sel`==`last_q` and `cont_q`=0): go to DONE.
    - Else if `BLANK`>0: go to BLANK.
    - Else: go to SCAN with the next row, `row_tick`=1 and `active` held at 1.
- **Next row:** `sel`+1, except `sel`==`last_q` wraps to 0 (mod-16 wrap is implied when `last_q`=15).
- **BLANK**
  - `sel` updates to the next row on entry, so the address settles while blanked.
  - `active`=0 for `BLANK` cycles, then go to SCAN with `row_tick`=1.
- **DONE:** one cycle with `done`=1, `busy`=1, `active`=0 and `sel` holding its value, then IDLE with `sel`=0.
- **Stop handling**
  - `stop` sets a sticky pending flag in any busy cycle.
  - The current row always completes its full dwell, and no further row starts.
  - A stop arriving during BLANK lets the already-selected next row complete its dwell, then terminates.
  - `start` and `stop` in the same IDLE cycle scan row 0 only, then go to DONE.
- `start` while busy is ignored. Changes to `last`/`cont` while busy have no effect.
- `last`=0 gives a single-row scan; in continuous mode row 0 repeats with blanks between.

## Timing
- Take `start` as sampled at edge E0.
- Row 0 is active during cycles 1..`DWELL`.
- Row k begins at cycle 1 + k·(`DWELL`+`BLANK`).
- Single pass with `last`=L:
  - `done` is high in cycle 1 + (L+1)·`DWELL` + L·`BLANK`.
  - IDLE follows in the next cycle.
  - Earliest re-`start` is in the IDLE cycle.
- `row_tick` coincides with the first `active` cycle of every row.
- There is no blank between the final row and DONE.
- Latency from `start` to first `active` is 1 cycle.

## Test plan
- **Reset:** hold `rst` for 2 cycles, including one mid-scan at row 2 → next cycle `sel`=0, `active`=`busy`=`done`=`row_tick`=0; a fresh `start` then scans normally from row 0.
- **Single pass:** `DWELL`=4, `BLANK`=1, `last`=3, `cont`=0, `start` at E0.
  - `sel` 0/1/2/3 active in cycles 1–4, 6–9, 11–14, 16–19.
  - `active`=0 in cycles 5, 10, 15.
  - `row_tick` in cycles 1, 6, 11, 16.
  - `done` in cycle 20; IDLE in cycle 21.
- **Continuous with wrap and stop:** `DWELL`=4, `BLANK`=1, `last`=15, `cont`=1.
  - Row 15 is followed by a blank, then `sel`=0 with `row_tick`.
  - Pulse `stop` in the 2nd cycle of row 5 → row 5 completes all 4 cycles, `done` next cycle, no row 6.
- **Degenerate scans:**
  - `last`=0, `cont`=0 → one 4-cycle row, `done` in cycle 5.
  - `start`+`stop` together with `last`=7 → same result.
- **No blanking:** `BLANK`=0, `DWELL`=2, `last`=2 → `sel` 0,0,1,1,2,2 back-to-back, `active` continuously 1 for 6 cycles, `done` in cycle 7.
- **Ignored inputs:**
  - `start` pulsed at row 1 of a running pass → no restart.
  - `last` changed from 3 to 9 mid-scan → scan still ends after row 3.
